// File: rtl/txbl_console_writer.sv
// Text console writer: accepts characters over valid/ready and writes TXBL entries
// through the VRAM write port, keeping a cursor and clearing the screen on form feed.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module txbl_console_writer #(
  parameter int          ADDR_W    = `VRAM_ADDR_WIDTH,
  parameter logic [11:0] TXBL_BASE = 12'h900,
  parameter int          ROWS      = 30,
  parameter int          COLS      = 32,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_char,
  input  logic              in_color,
  input  logic              bus_grant,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] vram_address,
  output logic              write_enable,
  output logic              SELECT_txbl,
  output logic [4:0]        cursor_row,
  output logic [4:0]        cursor_col,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [4:0]        LAST_COL  = 5'(COLS - 1);
  localparam logic [9:0]        LAST_IDX  = 10'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(TXBL_BASE);

  state_t              state_reg, state_next;
  logic [4:0]          row_reg, row_next;
  logic [4:0]          col_reg, col_next;
  logic [9:0]          idx_reg, idx_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          data_reg, data_next;
  logic                we_reg, we_next;
  logic                ready_reg, ready_next;

  logic                accept;
  logic [4:0]          row_inc;

  // in_ready is only ever 1 while IDLE, so no extra state qualification is needed.
  assign accept  = in_valid && ready_reg;
  assign row_inc = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_char == 7'h0C)       state_next = CLEAR;
          else if (in_char >= 7'h20)  state_next = WRITE;
        end
      end
      WRITE:   if (bus_grant) state_next = IDLE;
      CLEAR:   if (bus_grant && idx_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    row_next  = row_reg;
    col_next  = col_reg;
    idx_next  = idx_reg;
    addr_next = addr_reg;
    data_next = data_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (in_char)
            7'h0A: begin
              col_next = 5'd0;
              row_next = row_inc;
            end
            7'h0D: col_next = 5'd0;
            7'h08: if (col_reg != 5'd0) col_next = col_reg - 5'd1;
            7'h0C: begin
              idx_next  = 10'd0;
              addr_next = BASE_ADDR;
              data_next = BLANK;
            end
            default: begin
              if (in_char >= 7'h20) begin
                data_next = {in_color, in_char};
                addr_next = BASE_ADDR + ADDR_W'({row_reg, col_reg});
              end
            end
          endcase
        end
      end
      WRITE: begin
        if (bus_grant) begin
          if (col_reg == LAST_COL) begin
            col_next = 5'd0;
            row_next = row_inc;
          end else begin
            col_next = col_reg + 5'd1;
          end
        end
      end
      CLEAR: begin
        if (bus_grant) begin
          if (idx_reg == LAST_IDX) begin
            row_next = 5'd0;
            col_next = 5'd0;
          end else begin
            idx_next  = idx_reg + 10'd1;
            addr_next = BASE_ADDR + ADDR_W'(idx_reg + 10'd1);
          end
        end
      end
      default: ;
    endcase
    // Flags are derived from the next state so the registered outputs track state_reg.
    we_next    = (state_next != IDLE);
    ready_next = (state_next == IDLE);
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      row_reg   <= 5'd0;
      col_reg   <= 5'd0;
      idx_reg   <= 10'd0;
      addr_reg  <= '0;
      data_reg  <= 8'd0;
      we_reg    <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      row_reg   <= row_next;
      col_reg   <= col_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      we_reg    <= we_next;
      ready_reg <= ready_next;
    end
  end

  assign in_ready     = ready_reg;
  assign data_out     = data_reg;
  assign vram_address = addr_reg;
  assign write_enable = we_reg;
  assign SELECT_txbl  = we_reg;
  assign cursor_row   = row_reg;
  assign cursor_col   = col_reg;
  assign busy         = we_reg;

endmodule
